post_proc_pipe: RTL and testbench

POST_PROC_PIPE -- requirements
Module: post_proc_pipe

---
 rtl/post_proc_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_post_proc_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/post_proc_pipe.sv
// -----------------------------------------------------------------------------
// post_proc_pipe
//
// Post-processing pipeline for LANES parallel signed lanes per beat:
//   stage 1 : saturating per-lane bias add
//   stage 2 : per-lane activation (none / ReLU / leaky ReLU / clamp)
//   FIFO    : DEPTH-beat output buffer with valid/ready handshake
// A batch counter marks every ROWS-th popped beat with out_last, and a sticky
// sat_flag records any saturation seen in the bias add.
//
// Ports
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : input beat may be accepted
//   in_data    : packed signed lanes, lane i at [i*DW +: DW]
//   act_mode   : 0 none, 1 ReLU, 2 leaky ReLU, 3 clamp (travels with the beat)
//   bias_load  : load bias_in into the bias register
//   bias_in    : packed signed per-lane bias
//   out_valid  : FIFO head valid
//   out_ready  : consumer accepts the head
//   out_data   : FIFO head (zero when empty)
//   out_last   : head is the last beat of a batch
//   sat_flag   : sticky saturation indicator
//   clr_flags  : clears sat_flag and the batch counter
// -----------------------------------------------------------------------------
module post_proc_pipe #(
    parameter int LANES       = 8,
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int LEAKY_SHIFT = 3,
    parameter int CLAMP_MAX   = 6,
    parameter int ROWS        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic [1:0]            act_mode,
    input  logic                  bias_load,
    input  logic [LANES*DW-1:0]   bias_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*DW-1:0]   out_data,
    output logic                  out_last,
    output logic                  sat_flag,
    input  logic                  clr_flags
);

    localparam int W  = LANES * DW;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // occupancy sum can reach DEPTH + 2 transiently in the compare
    localparam int CW = $clog2(DEPTH + 3);
    localparam int BW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic signed [DW-1:0] L_CLAMP    = DW'(CLAMP_MAX);
    localparam logic [PW-1:0]        L_PTR_LAST = PW'(DEPTH - 1);
    localparam logic [BW-1:0]        L_ROW_LAST = BW'(ROWS - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [W-1:0]  r_bias;
    logic          r_s1_valid;
    logic [W-1:0]  r_s1_data;
    logic [1:0]    r_s1_mode;
    logic          r_s2_valid;
    logic [W-1:0]  r_s2_data;
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [BW-1:0] r_batch;
    logic          r_sat;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_occ;
    logic [W-1:0]  w_s1_next;
    logic [W-1:0]  w_s2_next;
    logic [LANES-1:0] w_lane_sat;

    // Occupancy counts beats still in the pipe, so every accepted beat is
    // guaranteed a FIFO slot even though the stages never stall.
    assign w_occ    = r_count + CW'(r_s1_valid) + CW'(r_s2_valid);
    assign in_ready = (w_occ < CW'(DEPTH));
    assign w_accept = in_valid && in_ready;
    assign w_push   = r_s2_valid;
    assign out_valid = (r_count != '0);
    assign w_pop    = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Per-lane datapath
    // ------------------------------------------------------------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DW-1:0] w_x;
        logic signed [DW-1:0] w_b;
        logic signed [DW:0]   w_sum;
        logic                 w_ovf;
        logic signed [DW-1:0] w_y;
        logic signed [DW-1:0] w_act;

        assign w_x   = in_data[g*DW +: DW];
        assign w_b   = r_bias[g*DW +: DW];
        assign w_sum = {w_x[DW-1], w_x} + {w_b[DW-1], w_b};
        // overflow when the two top bits of the widened sum disagree
        assign w_ovf = w_sum[DW] ^ w_sum[DW-1];
        assign w_lane_sat[g] = w_ovf;
        assign w_s1_next[g*DW +: DW] = w_ovf
            ? (w_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
            : w_sum[DW-1:0];

        assign w_y = r_s1_data[g*DW +: DW];

        always_comb begin
            w_act = w_y;
            case (r_s1_mode)
                2'd1: begin
                    if (w_y[DW-1]) w_act = '0;
                end
                2'd2: begin
                    if (w_y[DW-1]) w_act = w_y >>> LEAKY_SHIFT;
                end
                2'd3: begin
                    if (w_y[DW-1])          w_act = '0;
                    else if (w_y > L_CLAMP) w_act = L_CLAMP;
                end
                default: w_act = w_y;
            endcase
        end

        assign w_s2_next[g*DW +: DW] = w_act;
    end

    // ------------------------------------------------------------------
    // Bias register and sticky saturation flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bias <= '0;
            r_sat  <= 1'b0;
        end else begin
            if (bias_load) r_bias <= bias_in;
            // a new saturation outranks a simultaneous clear
            if (w_accept && (|w_lane_sat)) r_sat <= 1'b1;
            else if (clr_flags)            r_sat <= 1'b0;
        end
    end

    assign sat_flag = r_sat;

    // ------------------------------------------------------------------
    // Stages 1 and 2 (free-running; data only loads with a valid beat)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 2'd0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_s1_next;
                r_s1_mode <= act_mode;
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2_data <= w_s2_next;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_s2_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == L_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == L_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // memory is not reset, so hide stale contents while empty
    assign out_data = out_valid ? r_mem[r_rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Batch counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_batch <= '0;
        end else if (clr_flags) begin
            r_batch <= '0;
        end else if (w_pop) begin
            r_batch <= (r_batch == L_ROW_LAST) ? '0 : r_batch + 1'b1;
        end
    end

    assign out_last = out_valid && (r_batch == L_ROW_LAST);

endmodule

// File: tb/tb_post_proc_pipe.sv
module tb_post_proc_pipe;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   act_mode;
    logic         bias_load;
    logic [W-1:0] bias_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         sat_flag;
    logic         clr_flags;

    int tests = 0;
    int fails = 0;

    post_proc_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .act_mode  (act_mode),
        .bias_load (bias_load),
        .bias_in   (bias_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sat_flag  (sat_flag),
        .clr_flags (clr_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] fill(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        act_mode  = 2'd0;
        bias_load = 1'b0;
        bias_in   = '0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic load_bias(input logic [7:0] b);
        bias_in   = fill(b);
        bias_load = 1'b1;
        step();
        bias_load = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] m);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        act_mode = m;
        for (int i = 0; i < 30 && !done; i++) begin
            if (in_ready) done = 1;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready never 1, required 1");
        end
    endtask

    task automatic get_beat(output logic [W-1:0] d, output logic l, input logic clr);
        bit done = 0;
        d = '0;
        l = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            if (out_valid) begin
                d = out_data;
                l = out_last;
                clr_flags = clr;
                done = 1;
            end
            step();
            clr_flags = 1'b0;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL get_timeout: out_valid never 1, required 1");
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests++; if (out_last !== 1'b0)  begin fails++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        tests++; if (sat_flag !== 1'b0)  begin fails++; $display("FAIL rst_sat_flag: got %b want 0", sat_flag); end
        tests++; if (out_data !== '0)    begin fails++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        step();
        rst = 1'b0;
        step();
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_bias_sat();
        logic [W-1:0] d;
        logic l;
        do_reset();
        load_bias(8'h01);
        send(fill(8'h7F), 2'd0);
        get_beat(d, l, 1'b0);
        tests++; if (d !== fill(8'h7F)) begin fails++; $display("FAIL sat_data: got %h want %h", d, fill(8'h7F)); end
        tests++; if (sat_flag !== 1'b1) begin fails++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
        send(fill(8'h10), 2'd0);
        get_beat(d, l, 1'b0);
        tests++; if (d !== fill(8'h11)) begin fails++; $display("FAIL bias_add: got %h want %h", d, fill(8'h11)); end
    endtask

    task automatic test_modes();
        logic [W-1:0] d;
        logic l;
        logic [7:0] xin [6]  = '{8'hF0, 8'hF0, 8'hF0, 8'h14, 8'h14, 8'h14};
        logic [1:0] mode [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        logic [7:0] want [6] = '{8'h00, 8'hFE, 8'h00, 8'h14, 8'h14, 8'h06};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            send(fill(xin[k]), mode[k]);
            get_beat(d, l, 1'b0);
            tests++;
            if (d !== fill(want[k])) begin
                fails++;
                $display("FAIL mode%0d_x%h: got %h want %h", mode[k], xin[k], d, fill(want[k]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        logic l;
        int idx = 0;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = fill(8'h20);
        for (int c = 0; c < 12; c++) begin
            if (in_ready && idx < 6) begin
                step();
                idx++;
                in_data = fill(8'h20 + 8'(idx));
                if (idx == 6) in_valid = 1'b0;
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
        tests++; if (idx !== 4)          begin fails++; $display("FAIL bp_accepted: got %0d want 4", idx); end
        tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        tests++; if (out_data !== fill(8'h20)) begin fails++; $display("FAIL bp_hold0: got %h want %h", out_data, fill(8'h20)); end
        step();
        tests++; if (out_data !== fill(8'h20)) begin fails++; $display("FAIL bp_hold1: got %h want %h", out_data, fill(8'h20)); end
        for (int k = 0; k < 4; k++) begin
            get_beat(d, l, 1'b0);
            tests++;
            if (d !== fill(8'h20 + 8'(k))) begin
                fails++;
                $display("FAIL bp_order%0d: got %h want %h", k, d, fill(8'h20 + 8'(k)));
            end
        end
        step();
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = fill(8'h01);
        act_mode  = 2'd0;
        for (int c = 1; c <= 20; c++) begin
            if (c <= 16) begin
                tests++;
                if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready%0d: got %b want 1", c, in_ready); end
            end
            step();
            if (c < 16) in_data = fill(8'(c + 1));
            else        in_valid = 1'b0;
            if (c >= 3 && c <= 18) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== fill(8'(c - 2)) || out_last !== (((c - 3) % 8) == 7)) begin
                    fails++;
                    $display("FAIL stream_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             c - 3, out_valid, out_data, out_last, fill(8'(c - 2)), (((c - 3) % 8) == 7));
                end
            end else begin
                tests++;
                if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_idle%0d: got %b want 0", c, out_valid); end
            end
        end
    endtask

    task automatic test_bias_same_edge();
        logic [W-1:0] d;
        logic l;
        do_reset();
        bias_in   = fill(8'h05);
        bias_load = 1'b1;
        in_valid  = 1'b1;
        in_data   = fill(8'h01);
        act_mode  = 2'd0;
        step();
        bias_load = 1'b0;
        step();
        in_valid = 1'b0;
        get_beat(d, l, 1'b0);
        tests++; if (d !== fill(8'h01)) begin fails++; $display("FAIL bias_old: got %h want %h", d, fill(8'h01)); end
        get_beat(d, l, 1'b0);
        tests++; if (d !== fill(8'h06)) begin fails++; $display("FAIL bias_new: got %h want %h", d, fill(8'h06)); end
    endtask

    task automatic test_clr();
        logic [W-1:0] d;
        logic l;
        do_reset();
        load_bias(8'h01);
        clr_flags = 1'b1;
        send(fill(8'h7F), 2'd0);
        clr_flags = 1'b0;
        tests++; if (sat_flag !== 1'b1) begin fails++; $display("FAIL clr_set_wins: got %b want 1", sat_flag); end
        get_beat(d, l, 1'b0);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        tests++; if (sat_flag !== 1'b0) begin fails++; $display("FAIL clr_sat: got %b want 0", sat_flag); end
        for (int k = 0; k < 3; k++) begin
            send(fill(8'h10), 2'd0);
            get_beat(d, l, (k == 2));
        end
        for (int k = 0; k < 8; k++) begin
            send(fill(8'h10), 2'd0);
            get_beat(d, l, 1'b0);
            tests++;
            if (l !== (k == 7)) begin fails++; $display("FAIL clr_pop_last%0d: got %b want %b", k, l, (k == 7)); end
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] d;
        logic l;
        do_reset();
        load_bias(8'h01);
        out_ready = 1'b0;
        send(fill(8'h7F), 2'd0);
        send(fill(8'h10), 2'd0);
        send(fill(8'h10), 2'd0);
        repeat (4) step();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_buffered: got %b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        tests++; if (sat_flag !== 1'b0)  begin fails++; $display("FAIL mid_sat_flag: got %b want 0", sat_flag); end
        tests++; if (out_data !== '0)    begin fails++; $display("FAIL mid_out_data: got %h want 0", out_data); end
        step();
        rst = 1'b0;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_no_partial: got %b want 0", out_valid); end
        for (int k = 0; k < 8; k++) begin
            send(fill(8'h10), 2'd0);
            get_beat(d, l, 1'b0);
            if (k == 0) begin
                tests++;
                if (d !== fill(8'h10)) begin fails++; $display("FAIL mid_bias_cleared: got %h want %h", d, fill(8'h10)); end
            end
            tests++;
            if (l !== (k == 7)) begin fails++; $display("FAIL mid_last%0d: got %b want %b", k, l, (k == 7)); end
        end
    endtask

    initial begin
        test_reset();
        test_bias_sat();
        test_modes();
        test_backpressure();
        test_stream();
        test_bias_same_edge();
        test_clr();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
